// File: rtl/ch_buffer_sequencer.sv
// ch_buffer_sequencer
// Per-channel fast-buffer sequencer for the PSEC6 sampling channel.
// Steps the NUM_BUF fast buffers through groups of BPE buffers, one
// group per accepted trigger. After an accepted trigger it can hold off
// further triggers for a programmable time. It raises STOP_REQUEST from
// the first accepted trigger and records triggers it could not take.
//
// Command handling: each command is checked in a fixed priority order:
// readout, stop, start, readout_done, then the trigger event. A command
// that is a no-op in the current state does not block the commands
// below it. For example, inst_readout in INIT lets an inst_start in the
// same cycle take effect.
module ch_buffer_sequencer #(
    parameter int NUM_BUF   = 4,
    parameter int CNT_W     = $clog2(NUM_BUF) + 1,
    parameter int HOLDOFF_W = 4
) (
    input  logic                 CLK,
    input  logic                 RSTB,
    input  logic                 trig,
    input  logic                 inst_start,
    input  logic                 inst_stop,
    input  logic                 inst_readout,
    input  logic                 readout_done,
    input  logic [1:0]           mode,
    input  logic [HOLDOFF_W-1:0] holdoff,
    output logic [NUM_BUF-1:0]   buf_active,
    output logic [2:0]           state,
    output logic [CNT_W-1:0]     trigger_cnt,
    output logic                 STOP_REQUEST,
    output logic                 missed
);

    localparam int LOG_N = $clog2(NUM_BUF);

    localparam logic [2:0] ST_INIT     = 3'd0;
    localparam logic [2:0] ST_SAMPLING = 3'd1;
    localparam logic [2:0] ST_HOLDOFF  = 3'd2;
    localparam logic [2:0] ST_FULL     = 3'd3;
    localparam logic [2:0] ST_STOPPED  = 3'd4;
    localparam logic [2:0] ST_READOUT  = 3'd5;

    // Trigger synchroniser and edge detect.
    logic r_trig_s1;
    logic r_trig_s2;
    logic r_trig_d;
    logic w_trig_evt;

    // Control state.
    logic [2:0]           r_state;
    logic [NUM_BUF-1:0]   r_buf_active;
    logic [CNT_W-1:0]     r_trigger_cnt;
    logic                 r_stop_request;
    logic                 r_missed;
    logic [HOLDOFF_W-1:0] r_hold_cnt;

    // Run configuration, latched at inst_start.
    logic [CNT_W-1:0]     r_bpe;
    logic [CNT_W-1:0]     r_events;
    logic [HOLDOFF_W-1:0] r_holdoff;

    // Values derived from the live mode input and used at inst_start.
    logic [CNT_W-1:0]     w_bpe_log;
    logic [CNT_W-1:0]     w_start_bpe;
    logic [CNT_W-1:0]     w_start_events;
    logic [NUM_BUF-1:0]   w_start_mask;
    logic [CNT_W-1:0]     w_cnt_next;
    logic                 w_stop_ok;

    // Two-flop synchroniser plus a delayed copy for rising-edge detection.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            r_trig_s1 <= 1'b0;
            r_trig_s2 <= 1'b0;
            r_trig_d  <= 1'b0;
        end else begin
            r_trig_s1 <= trig;
            r_trig_s2 <= r_trig_s1;
            r_trig_d  <= r_trig_s2;
        end
    end

    assign w_trig_evt = r_trig_s2 & ~r_trig_d;

    // Map mode to log2(BPE): mode 3 means all buffers.
    // Any mode asking for more buffers than exist is clipped to NUM_BUF.
    always_comb begin
        w_bpe_log = CNT_W'(LOG_N);
        if ((mode != 2'd3) && (CNT_W'(mode) < CNT_W'(LOG_N))) begin
            w_bpe_log = CNT_W'(mode);
        end
    end

    assign w_start_bpe    = CNT_W'(1) << w_bpe_log;
    assign w_start_events = CNT_W'(NUM_BUF) >> w_bpe_log;
    // The lowest BPE bits are set; when BPE == NUM_BUF the shift empties the
    // all-ones vector and the inversion gives all ones.
    assign w_start_mask   = ~({NUM_BUF{1'b1}} << w_start_bpe);
    assign w_cnt_next     = r_trigger_cnt + CNT_W'(1);
    assign w_stop_ok      = (r_state == ST_SAMPLING) || (r_state == ST_HOLDOFF) ||
                            (r_state == ST_FULL);

    // Main sequencer: prioritised commands first, then per-state trigger handling.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            r_state        <= ST_INIT;
            r_buf_active   <= '0;
            r_trigger_cnt  <= '0;
            r_stop_request <= 1'b0;
            r_missed       <= 1'b0;
            r_hold_cnt     <= '0;
            r_bpe          <= CNT_W'(1);
            r_events       <= CNT_W'(NUM_BUF);
            r_holdoff      <= '0;
        end else if (inst_readout && (r_state != ST_INIT)) begin
            r_state      <= ST_READOUT;
            r_buf_active <= '0;
        end else if (inst_stop && w_stop_ok) begin
            r_state      <= ST_STOPPED;
            r_buf_active <= '0;
        end else if (inst_start) begin
            r_state        <= ST_SAMPLING;
            r_bpe          <= w_start_bpe;
            r_events       <= w_start_events;
            r_holdoff      <= holdoff;
            r_buf_active   <= w_start_mask;
            r_trigger_cnt  <= '0;
            r_stop_request <= 1'b0;
            r_missed       <= 1'b0;
            r_hold_cnt     <= '0;
        end else if (readout_done && (r_state == ST_READOUT)) begin
            r_state        <= ST_INIT;
            r_trigger_cnt  <= '0;
            r_stop_request <= 1'b0;
        end else begin
            case (r_state)
                ST_SAMPLING: begin
                    if (w_trig_evt) begin
                        r_trigger_cnt  <= w_cnt_next;
                        r_stop_request <= 1'b1;
                        if (w_cnt_next >= r_events) begin
                            r_buf_active <= '0;
                            r_state      <= ST_FULL;
                        end else begin
                            // Next group starts sampling on the same edge: no dead time.
                            r_buf_active <= r_buf_active << r_bpe;
                            if (r_holdoff != '0) begin
                                r_state    <= ST_HOLDOFF;
                                r_hold_cnt <= r_holdoff;
                            end
                        end
                    end
                end
                ST_HOLDOFF: begin
                    if (w_trig_evt) begin
                        r_missed <= 1'b1;
                    end
                    // Loaded with holdoff on entry. Leaving when it would reach 0
                    // gives exactly holdoff cycles in this state.
                    r_hold_cnt <= r_hold_cnt - HOLDOFF_W'(1);
                    if (r_hold_cnt <= HOLDOFF_W'(1)) begin
                        r_state <= ST_SAMPLING;
                    end
                end
                ST_FULL: begin
                    if (w_trig_evt) begin
                        r_missed <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign buf_active   = r_buf_active;
    assign state        = r_state;
    assign trigger_cnt  = r_trigger_cnt;
    assign STOP_REQUEST = r_stop_request;
    assign missed       = r_missed;

endmodule
